// File: rtl/calc_pkg.sv
// Shared calculator definitions: field width defaults, collector state encoding, ALU opcodes.
// Pure declarations; no logic, no latency, no flow control.
package calc_pkg;

  localparam int OPC_W_DEF  = 4;
  localparam int DATA_W_DEF = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_OPC  = 3'd1;
  localparam state_t ST_OPA  = 3'd2;
  localparam state_t ST_OPB  = 3'd3;
  localparam state_t ST_PAR  = 3'd4;
  localparam state_t ST_HOLD = 3'd5;

  localparam logic [3:0] OPC_ADD = 4'h0;
  localparam logic [3:0] OPC_SUB = 4'h1;
  localparam logic [3:0] OPC_AND = 4'h2;
  localparam logic [3:0] OPC_OR  = 4'h3;
  localparam logic [3:0] OPC_XOR = 4'h4;
  localparam logic [3:0] OPC_SHL = 4'h5;
  localparam logic [3:0] OPC_SHR = 4'h6;
  localparam logic [3:0] OPC_CMP = 4'h7;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/field_shifter.sv
// Serial-in/parallel-out field register, MSB first; one bit per shift_en, clear wins over shift.
// Output updates the cycle after the enable; no backpressure of its own.
module field_shifter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         shift_en,
  input  logic         bit_in,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (shift_en) begin
      q_d = (q_q << 1) | W'(bit_in);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/cmd_frame_collector.sv
// Collects a serial opcode/operand_a/operand_b frame (optional even-parity bit with PARITY_CHECK_EN);
// frame_valid 1 clk after last bit, held until frame_ready; bits arriving while held are dropped and flag overrun.
module cmd_frame_collector
  import calc_pkg::*;
#(
  parameter int OPC_W  = OPC_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              input_key,
  input  logic              valid_cmd,
  input  logic              active,
  input  logic              mode,
  input  logic              frame_ready,
  output logic              frame_valid,
  output logic [OPC_W-1:0]  opcode,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic              frame_mode,
  output logic              overrun,
  output logic              frame_error
);

  localparam int CNT_W = $clog2(max_int(OPC_W, DATA_W) + 1);
  localparam logic [CNT_W-1:0] OPC_LAST  = CNT_W'(OPC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             overrun_q, overrun_d;
  logic             bit_evt;
  logic             clr_fields;
  logic             opc_en, opa_en, opb_en;
`ifdef PARITY_CHECK_EN
  logic             par_q, par_d;
  logic             err_q, err_d;
`endif

  assign bit_evt = valid_cmd & active;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    overrun_d  = overrun_q;
    clr_fields = 1'b0;
    opc_en     = 1'b0;
    opa_en     = 1'b0;
    opb_en     = 1'b0;
`ifdef PARITY_CHECK_EN
    par_d      = par_q;
    err_d      = err_q;
`endif

    // Losing active mid-frame throws away everything collected so far.
    if (!active && (state_q == ST_OPC || state_q == ST_OPA ||
                    state_q == ST_OPB || state_q == ST_PAR)) begin
      state_d    = ST_IDLE;
      cnt_d      = '0;
      mode_d     = 1'b0;
      clr_fields = 1'b1;
`ifdef PARITY_CHECK_EN
      par_d      = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_OPC: begin
          if (bit_evt) begin
            opc_en = 1'b1;
            if (state_q == ST_IDLE) begin
              mode_d = mode;
`ifdef PARITY_CHECK_EN
              par_d  = input_key;
`endif
            end else begin
`ifdef PARITY_CHECK_EN
              par_d  = par_q ^ input_key;
`endif
            end
            if (cnt_q == OPC_LAST) begin
              state_d = ST_OPA;
              cnt_d   = '0;
            end else begin
              state_d = ST_OPC;
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_OPA: begin
          if (bit_evt) begin
            opa_en = 1'b1;
`ifdef PARITY_CHECK_EN
            par_d  = par_q ^ input_key;
`endif
            if (cnt_q == DATA_LAST) begin
              state_d = ST_OPB;
              cnt_d   = '0;
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_OPB: begin
          if (bit_evt) begin
            opb_en = 1'b1;
`ifdef PARITY_CHECK_EN
            par_d  = par_q ^ input_key;
`endif
            if (cnt_q == DATA_LAST) begin
              cnt_d   = '0;
`ifdef PARITY_CHECK_EN
              state_d = ST_PAR;
`else
              state_d = ST_HOLD;
`endif
            end else begin
              cnt_d   = cnt_q + CNT_W'(1);
            end
          end
        end
        ST_PAR: begin
          if (bit_evt) begin
            state_d = ST_HOLD;
`ifdef PARITY_CHECK_EN
            err_d   = par_q ^ input_key;
`endif
          end
        end
        ST_HOLD: begin
          // No bypass: a bit landing here, even on the handshake cycle, is lost.
          if (bit_evt) begin
            overrun_d = 1'b1;
          end
          if (frame_ready) begin
            state_d = ST_IDLE;
`ifdef PARITY_CHECK_EN
            err_d   = 1'b0;
`endif
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef PARITY_CHECK_EN
      par_q     <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      overrun_q <= overrun_d;
`ifdef PARITY_CHECK_EN
      par_q     <= par_d;
      err_q     <= err_d;
`endif
    end
  end

  field_shifter #(.W(OPC_W)) u_opc (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr_fields),
    .shift_en (opc_en),
    .bit_in   (input_key),
    .q        (opcode)
  );

  field_shifter #(.W(DATA_W)) u_opa (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr_fields),
    .shift_en (opa_en),
    .bit_in   (input_key),
    .q        (operand_a)
  );

  field_shifter #(.W(DATA_W)) u_opb (
    .clk      (clk),
    .reset    (reset),
    .clr      (clr_fields),
    .shift_en (opb_en),
    .bit_in   (input_key),
    .q        (operand_b)
  );

  assign frame_valid = (state_q == ST_HOLD);
  assign frame_mode  = mode_q;
  assign overrun     = overrun_q;
`ifdef PARITY_CHECK_EN
  assign frame_error = err_q;
`else
  assign frame_error = 1'b0;
`endif

endmodule

// File: tb/tb_cmd_frame_collector.sv
// Directed plus randomized frames for cmd_frame_collector, checked against a field-slicing reference model.
module tb_cmd_frame_collector;

  localparam int OPC_W  = 4;
  localparam int DATA_W = 8;
  localparam int FL     = OPC_W + 2 * DATA_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              input_key;
  logic              valid_cmd;
  logic              active;
  logic              mode;
  logic              frame_ready;
  logic              frame_valid;
  logic [OPC_W-1:0]  opcode;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              frame_mode;
  logic              overrun;
  logic              frame_error;

  int n_asserts = 0;
  int n_fail    = 0;

  cmd_frame_collector #(.OPC_W(OPC_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .input_key   (input_key),
    .valid_cmd   (valid_cmd),
    .active      (active),
    .mode        (mode),
    .frame_ready (frame_ready),
    .frame_valid (frame_valid),
    .opcode      (opcode),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .frame_mode  (frame_mode),
    .overrun     (overrun),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: a frame is just the bit string, fields are its slices.
  function automatic logic [OPC_W-1:0] m_opc(input logic [FL-1:0] f);
    return f[FL-1 -: OPC_W];
  endfunction
  function automatic logic [DATA_W-1:0] m_a(input logic [FL-1:0] f);
    return f[2*DATA_W-1 -: DATA_W];
  endfunction
  function automatic logic [DATA_W-1:0] m_b(input logic [FL-1:0] f);
    return f[DATA_W-1:0];
  endfunction

  task automatic send_bit(input logic b, input int gap);
    valid_cmd = 1'b1;
    input_key = b;
    tick();
    valid_cmd = 1'b0;
    input_key = 1'($urandom);
    for (int g = 0; g < gap; g++) tick();
  endtask

  // Mode is only meaningful on the first bit; it is inverted afterwards.
  task automatic send_frame(input logic [FL-1:0] f, input int gap, input logic md, input logic pbit);
    for (int i = FL - 1; i >= 0; i--) begin
      mode = (i == FL - 1) ? md : ~md;
`ifdef PARITY_CHECK_EN
      send_bit(f[i], gap);
`else
      send_bit(f[i], (i == 0) ? 0 : gap);
`endif
    end
`ifdef PARITY_CHECK_EN
    send_bit(pbit, 0);
`else
    if (pbit === 1'bx) input_key = 1'b0;
`endif
  endtask

  task automatic check_fields(input string tag, input logic [FL-1:0] f, input logic md);
    check({tag, ".valid"}, 32'(frame_valid), 32'd1);
    check({tag, ".opcode"}, 32'(opcode), 32'(m_opc(f)));
    check({tag, ".operand_a"}, 32'(operand_a), 32'(m_a(f)));
    check({tag, ".operand_b"}, 32'(operand_b), 32'(m_b(f)));
    check({tag, ".mode"}, 32'(frame_mode), 32'(md));
  endtask

  initial begin
    logic [FL-1:0] f;
    logic          md;
    int            gap;
    int            hold;

    reset = 1'b1; input_key = 1'b0; valid_cmd = 1'b0; active = 1'b0;
    mode = 1'b0; frame_ready = 1'b0;
    tick(); tick();
    // Reset also has to win over an input bit.
    active = 1'b1; valid_cmd = 1'b1; input_key = 1'b1; mode = 1'b1;
    tick();
    valid_cmd = 1'b0;
    check("rst.valid", 32'(frame_valid), 0);
    check("rst.opcode", 32'(opcode), 0);
    check("rst.operand_a", 32'(operand_a), 0);
    check("rst.operand_b", 32'(operand_b), 0);
    check("rst.mode", 32'(frame_mode), 0);
    check("rst.overrun", 32'(overrun), 0);
    check("rst.frame_error", 32'(frame_error), 0);
    reset = 1'b0;
    tick();

    // Basic frame, ready already high.
    f = 20'h35AC3;
    frame_ready = 1'b1;
    send_frame(f, 0, 1'b1, ^f);
    check_fields("basic", f, 1'b1);
    check("basic.ferr", 32'(frame_error), 0);
    tick();
    check("basic.valid_drop", 32'(frame_valid), 0);

    // Backpressure for 10 clk, with active dropping in HOLD.
    frame_ready = 1'b0;
    send_frame(f, 0, 1'b0, ^f);
    active = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_fields("stall", f, 1'b0);
      tick();
    end
    active = 1'b1;
    frame_ready = 1'b1;
    tick();
    check("stall.valid_drop", 32'(frame_valid), 0);

    // Overrun: extra bit while pending, handshake in the same cycle as a second extra bit.
    frame_ready = 1'b0;
    send_frame(f, 0, 1'b1, ^f);
    check("ovr.before", 32'(overrun), 0);
    send_bit(1'b0, 0);
    check("ovr.set", 32'(overrun), 1);
    check_fields("ovr", f, 1'b1);
    frame_ready = 1'b1;
    send_bit(1'b1, 0);
    check("ovr.valid_drop", 32'(frame_valid), 0);
    check("ovr.sticky", 32'(overrun), 1);
    frame_ready = 1'b0;
    tick(); tick();
    check("ovr.no_new_frame", 32'(frame_valid), 0);
    check("ovr.sticky2", 32'(overrun), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ovr.cleared", 32'(overrun), 0);

    // Abort after 7 bits; bits with active low are ignored.
    f = 20'hFFFFF;
    for (int i = 0; i < 7; i++) send_bit(f[FL-1-i], 0);
    active = 1'b0;
    tick();
    valid_cmd = 1'b1; input_key = 1'b1;
    tick(); tick();
    valid_cmd = 1'b0;
    check("abort.valid", 32'(frame_valid), 0);
    active = 1'b1;
    tick();
    f = 20'h1FF00;
    frame_ready = 1'b1;
    send_frame(f, 0, 1'b0, ^f);
    check_fields("after_abort", f, 1'b0);
    tick();
    check("after_abort.valid_drop", 32'(frame_valid), 0);

    // Gaps of 3 idle clk between bits.
    f = 20'h35AC3;
    frame_ready = 1'b0;
    send_frame(f, 3, 1'b1, ^f);
    check_fields("gaps", f, 1'b1);
    frame_ready = 1'b1;
    tick();
    check("gaps.valid_drop", 32'(frame_valid), 0);

    // Randomized frames, gaps and stall lengths.
    for (int n = 0; n < 12; n++) begin
      f    = FL'($urandom);
      md   = 1'($urandom);
      gap  = $urandom_range(0, 2);
      hold = $urandom_range(0, 4);
      frame_ready = 1'b0;
      send_frame(f, gap, md, ^f);
      for (int h = 0; h < hold; h++) begin
        check_fields("rnd.hold", f, md);
        tick();
      end
      check_fields("rnd", f, md);
      check("rnd.ferr", 32'(frame_error), 0);
      check("rnd.overrun", 32'(overrun), 0);
      frame_ready = 1'b1;
      tick();
      check("rnd.valid_drop", 32'(frame_valid), 0);
    end

`ifdef PARITY_CHECK_EN
    f = 20'h35AC3;
    frame_ready = 1'b0;
    send_frame(f, 0, 1'b1, ~(^f));
    check_fields("par_bad", f, 1'b1);
    check("par_bad.ferr", 32'(frame_error), 1);
    frame_ready = 1'b1;
    tick();
    check("par_bad.ferr_clr", 32'(frame_error), 0);
    frame_ready = 1'b0;
    send_frame(f, 0, 1'b1, ^f);
    check("par_good.ferr", 32'(frame_error), 0);
    frame_ready = 1'b1;
    tick();
    for (int n = 0; n < 6; n++) begin
      logic pb;
      f  = FL'($urandom);
      pb = 1'($urandom);
      frame_ready = 1'b0;
      send_frame(f, 0, 1'b0, pb);
      check("par_rnd.ferr", 32'(frame_error), 32'((^f) ^ pb));
      frame_ready = 1'b1;
      tick();
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
